// File: rtl/chess_pkg.sv
// Shared constants, piece codes and scanner state encoding for the board
// layout consumer blocks.
package chess_pkg;

  localparam int CHESS_SQUARES = 64;
  localparam int SQUARE_WIDTH  = 8;
  localparam int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH;
  localparam int IDX_WIDTH     = 6;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = 6'd63;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] ROOK   = 3'd3;
  localparam logic [2:0] BISHOP = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam int SQ_WHITE   = 3;
  localparam int SQ_CURSOR  = 4;
  localparam int SQ_LOCK    = 5;
  localparam int SQ_LOCKCUR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } scanState_t;

  function automatic logic [SQUARE_WIDTH-1:0] squareAt(
    input logic [MATRIX_WIDTH-1:0] matrix,
    input logic [IDX_WIDTH-1:0]    idx
  );
    return matrix[idx*SQUARE_WIDTH +: SQUARE_WIDTH];
  endfunction

endpackage

// File: rtl/chess_square_decode.sv
// Splits one board square byte into its piece code and flag bits.
module chess_square_decode
  import chess_pkg::*;
(
  input  logic [SQUARE_WIDTH-1:0] Square,
  output logic [2:0]              Piece,
  output logic                    IsWhite,
  output logic                    Cursor,
  output logic                    LockSrc,
  output logic                    LockCursor
);

  // Bit 7 carries no drawable meaning; it only matters for change detection upstream.
  logic unusedBit7;
  assign unusedBit7 = Square[7];

  assign Piece      = Square[2:0];
  assign IsWhite    = Square[SQ_WHITE];
  assign Cursor     = Square[SQ_CURSOR];
  assign LockSrc    = Square[SQ_LOCK];
  assign LockCursor = Square[SQ_LOCKCUR];

endmodule

// File: rtl/chess_layout_scanner.sv
// Streams the board squares that changed since the last drawn frame (or all
// of them on a full refresh) to the draw engine, one decoded square at a time.
module chess_layout_scanner
  import chess_pkg::*;
(
  input  logic                    OutClock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Layout,
  input  logic                    FullRefresh,
  output logic                    SquareValid,
  input  logic                    SquareReady,
  output logic [IDX_WIDTH-1:0]    SquareIdx,
  output logic [2:0]              SquareX,
  output logic [2:0]              SquareY,
  output logic [2:0]              Piece,
  output logic                    IsWhite,
  output logic                    Cursor,
  output logic                    LockSrc,
  output logic                    LockCursor,
  output logic                    FrameDone,
  output logic                    Busy,
  output scanState_t              StateDbg
);

  scanState_t state, stateNext;

  logic [MATRIX_WIDTH-1:0] snapshot;
  logic [MATRIX_WIDTH-1:0] shadow;
  logic [IDX_WIDTH-1:0]    scanIdx;
  logic                    fullPend;
  logic                    fullFrame;

  logic [SQUARE_WIDTH-1:0] snapSq;
  logic [SQUARE_WIDTH-1:0] shadSq;
  logic                    trigger;
  logic                    dirty;
  logic                    handshake;
  logic                    capture;
  logic                    loadOut;
  logic                    advance;

  logic [2:0] decPiece;
  logic       decWhite, decCursor, decLock, decLockCur;

  chess_square_decode uDecode (
    .Square     (snapSq),
    .Piece      (decPiece),
    .IsWhite    (decWhite),
    .Cursor     (decCursor),
    .LockSrc    (decLock),
    .LockCursor (decLockCur)
  );

  assign snapSq    = squareAt(snapshot, scanIdx);
  assign shadSq    = squareAt(shadow, scanIdx);
  assign trigger   = (Layout != shadow) || fullPend;
  assign dirty     = fullFrame || (snapSq != shadSq);
  // Valid/ready: a record transfers on any rising edge where SquareValid and
  // SquareReady are both high; while SquareValid is high and SquareReady low,
  // every record output holds, and SquareValid never drops without a transfer.
  assign handshake = SquareValid && SquareReady;

  assign SquareX   = SquareIdx[2:0];
  assign SquareY   = SquareIdx[5:3];
  assign FrameDone = (state == DONE);
  assign Busy      = (state != IDLE);
  assign StateDbg  = state;

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    loadOut   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          capture   = 1'b1;
          stateNext = SCAN;
        end
      end
      SCAN: begin
        if (dirty) begin
          loadOut   = 1'b1;
          stateNext = EMIT;
        end else if (scanIdx == LAST_IDX) begin
          stateNext = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (scanIdx == LAST_IDX) begin
            stateNext = DONE;
          end else begin
            advance   = 1'b1;
            stateNext = SCAN;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge OutClock or posedge resetApp) begin
    if (resetApp) begin
      snapshot    <= '0;
      shadow      <= '0;
      scanIdx     <= '0;
      fullPend    <= 1'b1;
      fullFrame   <= 1'b0;
      SquareValid <= 1'b0;
      SquareIdx   <= '0;
      Piece       <= '0;
      IsWhite     <= 1'b0;
      Cursor      <= 1'b0;
      LockSrc     <= 1'b0;
      LockCursor  <= 1'b0;
    end else begin
      if (capture) begin
        // A refresh pulse landing on the capture cycle belongs to this frame.
        snapshot  <= Layout;
        fullFrame <= fullPend || FullRefresh;
        fullPend  <= 1'b0;
        scanIdx   <= '0;
      end else begin
        if (FullRefresh) fullPend <= 1'b1;
        if (advance)     scanIdx  <= scanIdx + 6'd1;
      end

      if (loadOut) begin
        SquareValid <= 1'b1;
        SquareIdx   <= scanIdx;
        Piece       <= decPiece;
        IsWhite     <= decWhite;
        Cursor      <= decCursor;
        LockSrc     <= decLock;
        LockCursor  <= decLockCur;
      end

      if (state == EMIT && handshake) begin
        shadow[scanIdx*SQUARE_WIDTH +: SQUARE_WIDTH] <= snapSq;
        SquareValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chess_layout_scanner.sv
// Directed bench for chess_layout_scanner: reference shadow model builds the
// expected record stream per frame; transferred records are compared in order.
module tb_chess_layout_scanner;
  import chess_pkg::*;

  localparam int W = 19;

  logic                    OutClock;
  logic                    resetApp;
  logic [MATRIX_WIDTH-1:0] Layout;
  logic                    FullRefresh;
  logic                    SquareValid;
  logic                    SquareReady;
  logic [5:0]              SquareIdx;
  logic [2:0]              SquareX, SquareY, Piece;
  logic                    IsWhite, Cursor, LockSrc, LockCursor;
  logic                    FrameDone, Busy;
  scanState_t              StateDbg;

  chess_layout_scanner dut (
    .OutClock    (OutClock),
    .resetApp    (resetApp),
    .Layout      (Layout),
    .FullRefresh (FullRefresh),
    .SquareValid (SquareValid),
    .SquareReady (SquareReady),
    .SquareIdx   (SquareIdx),
    .SquareX     (SquareX),
    .SquareY     (SquareY),
    .Piece       (Piece),
    .IsWhite     (IsWhite),
    .Cursor      (Cursor),
    .LockSrc     (LockSrc),
    .LockCursor  (LockCursor),
    .FrameDone   (FrameDone),
    .Busy        (Busy),
    .StateDbg    (StateDbg)
  );

  // ---------------- clock ----------------
  initial begin
    OutClock = 1'b0;
    forever #5 OutClock = ~OutClock;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]            exp_q[$];
  logic [W-1:0]            rec_q[$];
  logic [MATRIX_WIDTH-1:0] m_shadow;
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int frame_cnt = 0;
  int first_valid_cyc = -1;
  int done_cyc = -1;

  typedef struct {
    int         sq;
    logic [7:0] val;
    logic [2:0] piece;
    logic       white, cursor, lock, lockcur;
    logic [2:0] x, y;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [W-1:0] mk_rec(input int i, input logic [7:0] b);
    logic [5:0] idx;
    logic [2:0] x, y;
    idx = i[5:0];
    x = 3'(i % 8);
    y = 3'(i / 8);
    return {idx, b[2:0], b[3], b[4], b[5], b[6], x, y};
  endfunction

  function automatic logic [W-1:0] dut_rec();
    return {SquareIdx, Piece, IsWhite, Cursor, LockSrc, LockCursor, SquareX, SquareY};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Samples the values the next rising edge will see, then advances a cycle.
  task automatic tick();
    cycle++;
    if (SquareValid && SquareReady) rec_q.push_back(dut_rec());
    if (SquareValid && first_valid_cyc < 0) first_valid_cyc = cycle;
    if (FrameDone) begin
      frame_cnt++;
      done_cyc = cycle;
    end
    @(negedge OutClock);
  endtask

  task automatic build_expected(input bit full);
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = Layout[i*8 +: 8];
      if (full || b != m_shadow[i*8 +: 8]) exp_q.push_back(mk_rec(i, b));
    end
    m_shadow = Layout;
  endtask

  task automatic wait_frame(input string name, input int budget);
    int start;
    int n;
    start = frame_cnt;
    n = 0;
    while (frame_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(frame_cnt != start), 32'd1);
  endtask

  task automatic check_frame(input string name);
    check({name, "_count"}, 32'(rec_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++)
      check(name, 32'(rec_q[i]), 32'(exp_q[i]));
    rec_q.delete();
    exp_q.delete();
  endtask

  task automatic init_board();
    logic [7:0] back_row [8];
    back_row = '{8'h03, 8'h02, 8'h04, 8'h05, 8'h06, 8'h04, 8'h02, 8'h03};
    Layout = '0;
    for (int x = 0; x < 8; x++) begin
      Layout[x*8 +: 8]        = back_row[x];
      Layout[(8+x)*8 +: 8]    = 8'h01;
      Layout[(48+x)*8 +: 8]   = 8'h09;
      Layout[(56+x)*8 +: 8]   = back_row[x] | 8'h08;
    end
  endtask

  function automatic logic [21:0] all_outputs();
    return {SquareValid, SquareIdx, SquareX, SquareY, Piece, IsWhite, Cursor,
            LockSrc, LockCursor, FrameDone, Busy};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int busy_cycles;
    int n;
    logic [W-1:0] tv;
    logic [W-1:0] stall_rec;

    vecs[0] = '{sq: 26, val: 8'h10, piece: 3'd0, white: 0, cursor: 1, lock: 0, lockcur: 0, x: 3'd2, y: 3'd3};
    vecs[1] = '{sq: 0,  val: 8'h83, piece: 3'd3, white: 0, cursor: 0, lock: 0, lockcur: 0, x: 3'd0, y: 3'd0};
    vecs[2] = '{sq: 63, val: 8'h6B, piece: 3'd3, white: 1, cursor: 0, lock: 1, lockcur: 1, x: 3'd7, y: 3'd7};
    vecs[3] = '{sq: 35, val: 8'h2D, piece: 3'd5, white: 1, cursor: 0, lock: 1, lockcur: 0, x: 3'd3, y: 3'd4};
    vecs[4] = '{sq: 7,  val: 8'h56, piece: 3'd6, white: 0, cursor: 1, lock: 0, lockcur: 1, x: 3'd7, y: 3'd0};

    // Reset with the starting board and a ready draw engine.
    resetApp    = 1'b1;
    FullRefresh = 1'b0;
    SquareReady = 1'b1;
    m_shadow    = '0;
    init_board();
    @(negedge OutClock);
    tick();
    tick();
    check("reset_outputs", 32'(all_outputs()), 32'd0);
    check("reset_state", 32'(StateDbg), 32'(IDLE));

    resetApp = 1'b0;
    build_expected(1'b1);
    tick();
    check("capture_busy", {30'd0, Busy, SquareValid}, 32'b10);
    tick();
    check("first_valid", {SquareValid, 31'd0}, 32'h8000_0000);
    check("first_idx", 32'(SquareIdx), 32'd0);
    check("first_piece_rook", 32'(Piece), 32'(ROOK));
    wait_frame("full_frame_done", 400);
    check_frame("full_frame");
    check("framedone_one_cycle", 32'(FrameDone), 32'd0);

    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (Busy) busy_cycles++;
      tick();
    end
    check("no_second_frame", 32'(busy_cycles), 32'd0);

    // Table: one square changes per frame; exactly one decoded record expected.
    for (int v = 0; v < 5; v++) begin
      Layout[vecs[v].sq*8 +: 8] = vecs[v].val;
      build_expected(1'b0);
      first_valid_cyc = -1;
      wait_frame("vec_frame_done", 300);
      tv = {vecs[v].sq[5:0], vecs[v].piece, vecs[v].white, vecs[v].cursor,
            vecs[v].lock, vecs[v].lockcur, vecs[v].x, vecs[v].y};
      check("vec_rec_count", 32'(rec_q.size()), 32'd1);
      if (rec_q.size() > 0) check("vec_record", 32'(rec_q[0]), 32'(tv));
      check("vec_done_latency", 32'(done_cyc - first_valid_cyc), 32'(63 - vecs[v].sq + 1));
      check_frame("vec_frame");
    end

    // Pawn move 52 -> 44: two records, ascending order.
    Layout[52*8 +: 8] = 8'h00;
    Layout[44*8 +: 8] = 8'h09;
    build_expected(1'b0);
    wait_frame("move_frame_done", 300);
    check("move_count", 32'(rec_q.size()), 32'd2);
    if (rec_q.size() == 2) begin
      check("move_first", 32'(rec_q[0]), 32'(mk_rec(44, 8'h09)));
      check("move_second", 32'(rec_q[1]), 32'(mk_rec(52, 8'h00)));
    end
    check_frame("move_frame");

    // Stall on square 5 for 10 cycles; square 10 changes during the stall.
    SquareReady = 1'b0;
    Layout[5*8 +: 8] = 8'h14;
    build_expected(1'b0);
    stall_rec = {6'd5, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0};
    n = 0;
    while (!SquareValid && n < 100) begin
      tick();
      n++;
    end
    check("stall_valid_seen", 32'(SquareValid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) Layout[10*8 +: 8] = 8'h11;
      check("stall_frozen", {12'd0, SquareValid, Busy, 18'd0} | 32'(dut_rec()),
            {12'd0, 1'b1, 1'b1, 18'd0} | 32'(stall_rec));
      tick();
    end
    SquareReady = 1'b1;
    wait_frame("stall_frame_done", 300);
    check_frame("stall_frame");
    build_expected(1'b0);
    wait_frame("late_change_done", 300);
    check_frame("late_change_frame");

    // Refresh pulse while scanning: current frame completes, then a full frame.
    Layout[20*8 +: 8] = 8'h02;
    build_expected(1'b0);
    tick();
    check("refresh_in_scan", 32'(StateDbg), 32'(SCAN));
    FullRefresh = 1'b1;
    tick();
    FullRefresh = 1'b0;
    wait_frame("refresh_cur_done", 300);
    check_frame("refresh_cur_frame");
    build_expected(1'b1);
    wait_frame("refresh_full_done", 400);
    check_frame("refresh_full_frame");

    // Reset while a record is waiting in EMIT.
    SquareReady = 1'b0;
    Layout[30*8 +: 8] = 8'h05;
    n = 0;
    while (!SquareValid && n < 100) begin
      tick();
      n++;
    end
    check("rst_emit_state", 32'(StateDbg), 32'(EMIT));
    resetApp = 1'b1;
    #1;
    check("rst_async_outputs", 32'(all_outputs()), 32'd0);
    check("rst_async_state", 32'(StateDbg), 32'(IDLE));
    tick();
    tick();
    rec_q.delete();
    exp_q.delete();
    m_shadow = '0;
    build_expected(1'b1);
    resetApp = 1'b0;
    SquareReady = 1'b1;
    wait_frame("post_reset_done", 400);
    check_frame("post_reset_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
